// File: rtl/seq_pkg.sv
//------------------------------------------------------------------------------
// Module : seq_pkg
// Brief  : Shared types and constants for the sequence-detector front end.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  localparam int   c_default_width = 8;
  // Fill level seen by the detector whenever no word is being shifted.
  localparam logic c_idle_bit      = 1'b0;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_serializer_if.sv
//------------------------------------------------------------------------------
// Module : seq_serializer_if
// Brief  : Load handshake and serial output bundle of the serializer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_serializer_if #(
  parameter int WIDTH = seq_pkg::c_default_width
);

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             x_out;
  logic             x_valid;
  logic             busy;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  x_out,
    input  x_valid,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output x_out,
    output x_valid,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/seq_hold_buf.sv
//------------------------------------------------------------------------------
// Module : seq_hold_buf
// Brief  : One-entry WIDTH-bit holding register with a full flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_hold_buf #(
  parameter int WIDTH = seq_pkg::c_default_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // A write and a read never coincide: writes need the buffer empty,
  // reads need it full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (wr_en) begin
      r_data <= wr_data;
      r_full <= 1'b1;
    end else if (rd_en) begin
      r_full <= 1'b0;
    end
  end

  assign rd_data = r_data;
  assign full    = r_full;

endmodule

`default_nettype wire

// File: rtl/seq_serializer.sv
//------------------------------------------------------------------------------
// Module : seq_serializer
// Brief  : Parallel-to-serial front end feeding the sequence detector input.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = c_default_width,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = c_idle_bit
) (
  input  logic             clock,
  input  logic             reset,
  seq_serializer_if.slave  bus
);

  localparam int                 c_cnt_w   = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH - 1);

  ser_state_t         r_state;
  ser_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_head;
  logic               w_accept;
  logic               w_hold_wr;
  logic               w_hold_rd;
  logic               w_hold_full;
  logic [WIDTH-1:0]   w_hold_data;

  // Ready depends only on the hold flag, so no path from load_valid.
  assign w_accept = bus.load_valid && !w_hold_full;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_head    = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head    = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  seq_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_hold_wr),
    .wr_data (bus.data_in),
    .rd_en   (w_hold_rd),
    .rd_data (w_hold_data),
    .full    (w_hold_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_hold_wr   = 1'b0;
    w_hold_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = bus.data_in;
          w_cnt_nxt   = c_cnt_max;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt - c_cnt_w'(1);
          w_hold_wr   = w_accept;
        end else if (w_hold_full) begin
          w_hold_rd   = 1'b1;
          w_shift_nxt = w_hold_data;
          w_cnt_nxt   = c_cnt_max;
        end else if (w_accept) begin
          // Last bit and a fresh word on the same edge: no fill bit between.
          w_shift_nxt = bus.data_in;
          w_cnt_nxt   = c_cnt_max;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.load_ready = !w_hold_full;
  assign bus.x_valid    = (r_state == S_SHIFT);
  assign bus.x_out      = (r_state == S_SHIFT) ? w_head : IDLE_BIT;
  assign bus.busy       = (r_state == S_SHIFT) || w_hold_full;

endmodule

`default_nettype wire
